apb_area_requester: RTL and testbench

- APB initiator that drives the rectangle-area peripheral from the requester end of the APB link.
- Accepts a side pair (a, b) on a valid/ready request port and runs three back-to-back APB transfers: write a, write b, read area.
- Returns the area, or a timeout error, on a valid/ready response port.
- Sits between a local controller and the APB bus, in place of a testbench-driven master.

---
 rtl/apb_area_requester.sv | 136 +++++++++++++
 tb/tb_apb_area_requester.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_area_requester.sv
// rtl/apb_area_requester.sv - APB initiator that writes sides a/b and reads back the rectangle area
module apb_area_requester #(
    parameter logic [31:0] ADDR_A   = 32'd0,
    parameter logic [31:0] ADDR_B   = 32'd4,
    parameter logic [31:0] ADDR_RES = 32'd8,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_area,
    output logic        rsp_err,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    input  logic        PREADY
);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

    state_t      state;
    logic [1:0]  idx;
    logic [31:0] wait_cnt;
    logic [31:0] lat_a;
    logic [31:0] lat_b;

    // Handshake flags are pure state decodes; req_ready is masked while reset is held
    assign req_ready = (state == IDLE) && !PRESET;
    assign rsp_valid = (state == RESP);

    // Sequencer: three back-to-back APB transfers with all bus outputs registered
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            idx      <= 2'd0;
            wait_cnt <= 32'd0;
            lat_a    <= 32'd0;
            lat_b    <= 32'd0;
            PSEL     <= 1'b0;
            PENABLE  <= 1'b0;
            PWRITE   <= 1'b0;
            PADDR    <= 32'd0;
            PWDATA   <= 32'd0;
            rsp_area <= 32'd0;
            rsp_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_a    <= req_a;
                        lat_b    <= req_b;
                        idx      <= 2'd0;
                        wait_cnt <= 32'd0;
                        state    <= SETUP;
                        PSEL     <= 1'b1;
                        PENABLE  <= 1'b0;
                        PWRITE   <= 1'b1;
                        PADDR    <= ADDR_A;
                        PWDATA   <= req_a;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        if (idx == 2'd2) begin
                            rsp_area <= PRDATA;
                            rsp_err  <= 1'b0;
                            state    <= RESP;
                            PSEL     <= 1'b0;
                            PENABLE  <= 1'b0;
                            PWRITE   <= 1'b0;
                            PADDR    <= 32'd0;
                            PWDATA   <= 32'd0;
                        end else begin
                            // Chain straight into the next SETUP with PSEL kept high
                            idx      <= idx + 2'd1;
                            wait_cnt <= 32'd0;
                            state    <= SETUP;
                            PENABLE  <= 1'b0;
                            if (idx == 2'd0) begin
                                PWRITE <= 1'b1;
                                PADDR  <= ADDR_B;
                                PWDATA <= lat_b;
                            end else begin
                                PWRITE <= 1'b0;
                                PADDR  <= ADDR_RES;
                                PWDATA <= 32'd0;
                            end
                        end
                    end else if ((TIMEOUT != 0) && (wait_cnt + 32'd1 == TIMEOUT_W)) begin
                        // Slave stalled too long: drop the remaining transfers and report
                        rsp_area <= 32'd0;
                        rsp_err  <= 1'b1;
                        wait_cnt <= 32'd0;
                        state    <= RESP;
                        PSEL     <= 1'b0;
                        PENABLE  <= 1'b0;
                        PWRITE   <= 1'b0;
                        PADDR    <= 32'd0;
                        PWDATA   <= 32'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        idx   <= 2'd0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_area_requester.sv
// tb/tb_apb_area_requester.sv - scoreboard bench for apb_area_requester with a multiplying APB slave
module tb_apb_area_requester;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid [2];
    logic        req_ready [2];
    logic [31:0] req_a     [2];
    logic [31:0] req_b     [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_area  [2];
    logic        rsp_err   [2];
    logic        psel      [2];
    logic        penable   [2];
    logic        pwrite    [2];
    logic [31:0] paddr     [2];
    logic [31:0] pwdata    [2];
    logic [31:0] prdata    [2];
    logic        pready    [2];
    int          rd_wait   [2];
    logic        hang_b    [2];

    typedef struct { logic [31:0] area; logic err; int lat; } rsp_t;
    typedef struct { logic wr; logic [31:0] addr; logic [31:0] data; } xfer_t;

    rsp_t  rsp_q[$];
    xfer_t xfer_q[$];

    int checks = 0;
    int errors = 0;
    int act = 0;
    int cyc = 0;
    int acc_edge = 0;
    int psel_run = 0;
    int last_run = 0;
    bit seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Instance 0 has TIMEOUT=4, instance 1 has the timeout disabled; each has its own slave
    for (genvar g = 0; g < 2; g++) begin : gen_u
        logic [31:0] mem_a = 32'd0;
        logic [31:0] mem_b = 32'd0;
        int cnt = 0;
        assign pready[g] = psel[g] && penable[g] && !(hang_b[g] && paddr[g] == 32'd4)
                           && (cnt >= ((paddr[g] == 32'd8) ? rd_wait[g] : 0));
        assign prdata[g] = mem_a * mem_b;
        always @(posedge clk) begin
            cnt <= (psel[g] && penable[g] && !pready[g]) ? cnt + 1 : 0;
            if (pready[g] && pwrite[g] && paddr[g] == 32'd0) mem_a <= pwdata[g];
            if (pready[g] && pwrite[g] && paddr[g] == 32'd4) mem_b <= pwdata[g];
        end
        apb_area_requester #(.TIMEOUT((g == 0) ? 4 : 0)) dut (
            .PCLK(clk), .PRESET(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_a(req_a[g]), .req_b(req_b[g]),
            .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
            .rsp_area(rsp_area[g]), .rsp_err(rsp_err[g]),
            .PSEL(psel[g]), .PENABLE(penable[g]), .PWRITE(pwrite[g]),
            .PADDR(paddr[g]), .PWDATA(pwdata[g]),
            .PRDATA(prdata[g]), .PREADY(pready[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at cycle %0d", name, got, exp, cyc);
        end
    endtask

    task automatic expect_req(input logic [31:0] a, input logic [31:0] b, input int lat);
        xfer_q.push_back('{1'b1, 32'd0, a});
        xfer_q.push_back('{1'b1, 32'd4, b});
        xfer_q.push_back('{1'b0, 32'd8, 32'd0});
        rsp_q.push_back('{a * b, 1'b0, lat});
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        bit ok = 1'b0;
        req_a[act] = a;
        req_b[act] = b;
        req_valid[act] = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready[act];
        end
        chk("req_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1 req_valid[act] = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && rsp_q.size() != 0; i++) @(negedge clk);
        chk("rsp_drain", 32'(rsp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares APB phases and responses of the active instance against the queues
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req_valid[act] && req_ready[act]) acc_edge = cyc + 1;
                if (psel[act]) begin
                    psel_run++;
                    if (xfer_q.size() == 0) begin
                        chk("apb_unexpected_psel", 32'(psel[act]), 32'd0);
                    end else begin
                        chk("paddr", paddr[act], xfer_q[0].addr);
                        chk("pwrite", 32'(pwrite[act]), 32'(xfer_q[0].wr));
                        chk("pwdata", pwdata[act], xfer_q[0].data);
                        if (penable[act] && pready[act]) void'(xfer_q.pop_front());
                    end
                end else if (psel_run != 0) begin
                    last_run = psel_run;
                    psel_run = 0;
                end
                if (rsp_valid[act]) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected_valid", 32'(rsp_valid[act]), 32'd0);
                    end else begin
                        if (!seen) begin
                            chk("rsp_latency", 32'(cyc - acc_edge + 1), 32'(rsp_q[0].lat));
                            seen = 1'b1;
                        end
                        chk("rsp_area", rsp_area[act], rsp_q[0].area);
                        chk("rsp_err", 32'(rsp_err[act]), 32'(rsp_q[0].err));
                        if (rsp_ready[act]) begin
                            void'(rsp_q.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0;
            req_a[u]     = 32'd0;
            req_b[u]     = 32'd0;
            rsp_ready[u] = 1'b1;
            rd_wait[u]   = 0;
            hang_b[u]    = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready[0]), 32'd0);
        chk("reset_psel", 32'(psel[0]), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        chk("reset_paddr", paddr[0], 32'd0);
        chk("reset_rsp_area", rsp_area[0], 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1;

        // Zero-wait slave: 5*7
        expect_req(32'd5, 32'd7, 7);
        send(32'd5, 32'd7);
        wait_done();
        chk("psel_run_zero_wait", 32'(last_run), 32'd6);

        // Two wait states on the read
        rd_wait[0] = 2;
        expect_req(32'd5, 32'd7, 9);
        send(32'd5, 32'd7);
        wait_done();
        chk("psel_run_read_wait", 32'(last_run), 32'd8);
        rd_wait[0] = 0;

        // Consumer stalls the response; a second request waits behind it
        rsp_ready[0] = 1'b0;
        expect_req(32'd3, 32'd7, 7);
        send(32'd3, 32'd7);
        for (int i = 0; i < 50 && !rsp_valid[0]; i++) @(negedge clk);
        chk("stall_rsp_valid_seen", 32'(rsp_valid[0]), 32'd1);
        @(posedge clk);
        #1;
        expect_req(32'd4, 32'd5, 7);
        req_a[0] = 32'd4;
        req_b[0] = 32'd5;
        req_valid[0] = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("stall_req_ready", 32'(req_ready[0]), 32'd0);
            chk("stall_rsp_valid", 32'(rsp_valid[0]), 32'd1);
        end
        @(posedge clk);
        #1 rsp_ready[0] = 1'b1;
        @(negedge clk);
        chk("handshake_req_ready", 32'(req_ready[0]), 32'd0);
        @(negedge clk);
        chk("after_handshake_req_ready", 32'(req_ready[0]), 32'd1);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        wait_done();

        // Slave never completes the write to side b: TIMEOUT=4 aborts
        hang_b[0] = 1'b1;
        xfer_q.push_back('{1'b1, 32'd0, 32'd9});
        xfer_q.push_back('{1'b1, 32'd4, 32'd6});
        rsp_q.push_back('{32'd0, 1'b1, 8});
        send(32'd9, 32'd6);
        wait_done();
        chk("psel_run_timeout", 32'(last_run), 32'd7);
        chk("timeout_skipped_xfers", 32'(xfer_q.size()), 32'd1);
        xfer_q.delete();
        hang_b[0] = 1'b0;

        // Reset pulse during the ACCESS phase of the write to side b
        xfer_q.push_back('{1'b1, 32'd0, 32'd6});
        xfer_q.push_back('{1'b1, 32'd4, 32'd6});
        send(32'd6, 32'd6);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_access", {paddr[0][29:0], psel[0], penable[0]}, {30'd4, 1'b1, 1'b1});
        rst = 1'b1;
        #1;
        chk("async_reset_psel", 32'(psel[0]), 32'd0);
        chk("async_reset_penable", 32'(penable[0]), 32'd0);
        chk("async_reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        xfer_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", 32'(req_ready[0]), 32'd1);
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        expect_req(32'd2, 32'd2, 7);
        send(32'd2, 32'd2);
        wait_done();

        // Timeout disabled, 40 wait states on the read
        act = 1;
        rd_wait[1] = 40;
        expect_req(32'd5, 32'd7, 47);
        send(32'd5, 32'd7);
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
